// File: rtl/ines_loader.sv
// iNES cartridge image loader.
// Consumes a .nes file one byte at a time, validates the 16-byte header,
// skips an optional 512-byte trainer, and streams PRG then CHR bytes out
// as single-cycle write strobes. The CPU/PPU are held until the image is in.
module ines_loader #(
   parameter int PRG_BYTES = 16384,
   parameter int CHR_BYTES = 8192
) (
   input  logic        cpu_clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        prg_we,
   output logic [13:0] prg_addr,
   output logic [7:0]  prg_wd,
   output logic        chr_we,
   output logic [12:0] chr_addr,
   output logic [7:0]  chr_wd,
   output logic        cpu_hold,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   typedef enum logic [2:0] {HDR, TRAIN, PRG, CHR, DONE, ERR} state_t;

   localparam logic [7:0]  PRG_UNITS  = 8'(PRG_BYTES / 16384);
   localparam logic [7:0]  CHR_UNITS  = 8'(CHR_BYTES / 8192);
   localparam logic [13:0] PRG_LAST   = 14'(PRG_BYTES - 1);
   localparam logic [13:0] CHR_LAST   = 14'(CHR_BYTES - 1);
   localparam logic [13:0] TRAIN_LAST = 14'd511;

   state_t      state, state_next;
   logic [13:0] count, count_next;
   logic [3:0]  mapper_lo, mapper_lo_next;
   logic        trainer, trainer_next;
   logic [1:0]  err_code_next;
   logic        take;

   assign in_ready = (state != DONE) && (state != ERR);
   assign take     = in_valid && in_ready;
   assign done     = (state == DONE);
   assign err      = (state == ERR);
   assign cpu_hold = (state != DONE);

   // State, byte counter and the header fields kept between bytes 6 and 7
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         state     <= HDR;
         count     <= 14'd0;
         mapper_lo <= 4'd0;
         trainer   <= 1'b0;
         err_code  <= 2'b00;
      end else begin
         state     <= state_next;
         count     <= count_next;
         mapper_lo <= mapper_lo_next;
         trainer   <= trainer_next;
         err_code  <= err_code_next;
      end
   end

   // Next-state logic: header checks byte by byte, then length-counted sections
   always_comb begin
      state_next     = state;
      count_next     = count;
      mapper_lo_next = mapper_lo;
      trainer_next   = trainer;
      err_code_next  = err_code;
      if (take) begin
         case (state)
            HDR: begin
               count_next = count + 14'd1;
               case (count[3:0])
                  4'd0: if (in_data != 8'h4E) begin state_next = ERR; err_code_next = 2'b01; end
                  4'd1: if (in_data != 8'h45) begin state_next = ERR; err_code_next = 2'b01; end
                  4'd2: if (in_data != 8'h53) begin state_next = ERR; err_code_next = 2'b01; end
                  4'd3: if (in_data != 8'h1A) begin state_next = ERR; err_code_next = 2'b01; end
                  4'd4: if (in_data != PRG_UNITS) begin state_next = ERR; err_code_next = 2'b10; end
                  4'd5: if (in_data != CHR_UNITS) begin state_next = ERR; err_code_next = 2'b10; end
                  4'd6: begin
                     mapper_lo_next = in_data[7:4];
                     trainer_next   = in_data[2];
                  end
                  4'd7: if ({in_data[7:4], mapper_lo} != 8'h00) begin
                     state_next    = ERR;
                     err_code_next = 2'b11;
                  end
                  4'd15: begin
                     state_next = trainer ? TRAIN : PRG;
                     count_next = 14'd0;
                  end
                  default: ;
               endcase
            end
            TRAIN: begin
               if (count == TRAIN_LAST) begin
                  state_next = PRG;
                  count_next = 14'd0;
               end else begin
                  count_next = count + 14'd1;
               end
            end
            PRG: begin
               if (count == PRG_LAST) begin
                  state_next = CHR;
                  count_next = 14'd0;
               end else begin
                  count_next = count + 14'd1;
               end
            end
            CHR: begin
               if (count == CHR_LAST) begin
                  state_next = DONE;
                  count_next = 14'd0;
               end else begin
                  count_next = count + 14'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Write ports: registered so each accepted section byte appears for exactly the next cycle
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         prg_we   <= 1'b0;
         prg_addr <= 14'd0;
         prg_wd   <= 8'd0;
         chr_we   <= 1'b0;
         chr_addr <= 13'd0;
         chr_wd   <= 8'd0;
      end else begin
         prg_we <= take && (state == PRG);
         chr_we <= take && (state == CHR);
         if (take && (state == PRG)) begin
            prg_addr <= count;
            prg_wd   <= in_data;
         end
         if (take && (state == CHR)) begin
            chr_addr <= count[12:0];
            chr_wd   <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_ines_loader.sv
// Directed bench for ines_loader: reset state, header rejects, trainer skip,
// mid-load reset and a full image load with random input gaps.
module tb_ines_loader;

   logic        cpu_clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        in_ready;
   logic        prg_we;
   logic [13:0] prg_addr;
   logic [7:0]  prg_wd;
   logic        chr_we;
   logic [12:0] chr_addr;
   logic [7:0]  chr_wd;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   int checks = 0;
   int failures = 0;
   int accepts = 0;

   int prg_strobes = 0;
   int chr_strobes = 0;
   int seq_errs = 0;
   int both_we = 0;
   int ff_strobes = 0;
   int final_ok = 0;

   ines_loader dut (
      .cpu_clk (cpu_clk),
      .rst     (rst),
      .in_valid(in_valid),
      .in_data (in_data),
      .in_ready(in_ready),
      .prg_we  (prg_we),
      .prg_addr(prg_addr),
      .prg_wd  (prg_wd),
      .chr_we  (chr_we),
      .chr_addr(chr_addr),
      .chr_wd  (chr_wd),
      .cpu_hold(cpu_hold),
      .done    (done),
      .err     (err),
      .err_code(err_code)
   );

   // Free-running 100 MHz clock
   always #5 cpu_clk = ~cpu_clk;

   // Strobe scoreboard: each write must land at the next expected address with the expected data
   always @(negedge cpu_clk) begin
      if (prg_we) begin
         if ({18'd0, prg_addr} != prg_strobes || prg_wd != prg_strobes[7:0]) seq_errs++;
         if (prg_wd == 8'hFF) ff_strobes++;
         prg_strobes++;
      end
      if (chr_we) begin
         if ({19'd0, chr_addr} != chr_strobes || chr_wd != (chr_strobes[7:0] ^ 8'hA5)) seq_errs++;
         if (chr_wd == 8'hFF) ff_strobes++;
         if (chr_addr == 13'h1FFF && done && !cpu_hold) final_ok++;
         chr_strobes++;
      end
      if (prg_we && chr_we) both_we++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clearMonitor();
      prg_strobes = 0;
      chr_strobes = 0;
      seq_errs    = 0;
      both_we     = 0;
      ff_strobes  = 0;
      final_ok    = 0;
      accepts     = 0;
   endtask

   task automatic resetDut();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'd0;
      @(negedge cpu_clk);
      #2 clearMonitor();
      @(negedge cpu_clk);
      rst = 1'b0;
   endtask

   // Offers one byte for a single cycle, optionally preceded by random idle cycles
   task automatic applyStimulus(input logic [7:0] b, input bit gaps);
      if (gaps) begin
         for (int g = 0; g < 8 && $urandom_range(0, 1) == 0; g++) begin
            in_valid = 1'b0;
            @(negedge cpu_clk);
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready) accepts++;
      @(negedge cpu_clk);
      in_valid = 1'b0;
   endtask

   task automatic sendHeader(input logic [7:0] f6, input bit gaps);
      logic [7:0] hdr [16];
      for (int i = 0; i < 16; i++) hdr[i] = 8'h00;
      hdr[0] = 8'h4E; hdr[1] = 8'h45; hdr[2] = 8'h53; hdr[3] = 8'h1A;
      hdr[4] = 8'h01; hdr[5] = 8'h01; hdr[6] = f6;
      for (int i = 0; i < 16; i++) applyStimulus(hdr[i], gaps);
   endtask

   initial begin
      $display("[TB] ines_loader bench start");

      // Reset state
      resetDut();
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_prg_we", 32'(prg_we), 32'd0);
      checkOutput("rst_chr_we", 32'(chr_we), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_err_code", 32'(err_code), 32'd0);
      checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
      checkOutput("rst_addr", {5'd0, prg_addr, chr_addr}, 32'd0);

      // Bad magic at byte 2
      resetDut();
      applyStimulus(8'h4E, 1'b0);
      applyStimulus(8'h45, 1'b0);
      checkOutput("magic_not_yet_err", 32'(err), 32'd0);
      applyStimulus(8'h54, 1'b0);
      checkOutput("magic_err", 32'(err), 32'd1);
      checkOutput("magic_err_code", 32'(err_code), 32'd1);
      checkOutput("magic_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 20; i++) applyStimulus(8'(i), 1'b0);
      #1;
      checkOutput("magic_no_strobes", 32'(prg_strobes + chr_strobes), 32'd0);
      checkOutput("magic_accepts", 32'(accepts), 32'd3);
      checkOutput("magic_cpu_hold", 32'(cpu_hold), 32'd1);

      // Bad PRG size at byte 4
      resetDut();
      applyStimulus(8'h4E, 1'b0);
      applyStimulus(8'h45, 1'b0);
      applyStimulus(8'h53, 1'b0);
      applyStimulus(8'h1A, 1'b0);
      applyStimulus(8'h02, 1'b0);
      checkOutput("size_err", 32'(err), 32'd1);
      checkOutput("size_err_code", 32'(err_code), 32'd2);

      // Nonzero mapper flagged at byte 7, not byte 6
      resetDut();
      applyStimulus(8'h4E, 1'b0);
      applyStimulus(8'h45, 1'b0);
      applyStimulus(8'h53, 1'b0);
      applyStimulus(8'h1A, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h10, 1'b0);
      checkOutput("mapper_after_b6", 32'(err), 32'd0);
      applyStimulus(8'h00, 1'b0);
      checkOutput("mapper_err", 32'(err), 32'd1);
      checkOutput("mapper_err_code", 32'(err_code), 32'd3);

      // Trainer skip: 512 bytes of FF must never reach a write port
      resetDut();
      sendHeader(8'h04, 1'b0);
      for (int i = 0; i < 512; i++) applyStimulus(8'hFF, 1'b0);
      checkOutput("train_no_strobe", 32'(prg_we), 32'd0);
      applyStimulus(8'h00, 1'b0);
      checkOutput("train_first_we", 32'(prg_we), 32'd1);
      checkOutput("train_first_addr", 32'(prg_addr), 32'd0);
      checkOutput("train_first_wd", 32'(prg_wd), 32'd0);
      @(negedge cpu_clk);
      checkOutput("train_we_one_cycle", 32'(prg_we), 32'd0);
      applyStimulus(8'h01, 1'b0);
      checkOutput("train_second_addr", 32'(prg_addr), 32'd1);
      checkOutput("train_second_wd", 32'(prg_wd), 32'd1);
      #1;
      checkOutput("train_ff_strobes", 32'(ff_strobes), 32'd0);
      checkOutput("train_strobe_count", 32'(prg_strobes), 32'd2);

      // Reset after 100 PRG bytes, with a byte offered on the reset edge
      resetDut();
      sendHeader(8'h00, 1'b0);
      for (int i = 0; i < 100; i++) applyStimulus(8'(i), 1'b0);
      in_valid = 1'b1;
      in_data  = 8'd100;
      rst      = 1'b1;
      @(negedge cpu_clk);
      in_valid = 1'b0;
      checkOutput("midrst_prg_we", 32'(prg_we), 32'd0);
      checkOutput("midrst_prg_addr", 32'(prg_addr), 32'd0);
      checkOutput("midrst_prg_wd", 32'(prg_wd), 32'd0);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
      #1;
      checkOutput("midrst_strobes", 32'(prg_strobes), 32'd100);
      checkOutput("midrst_seq", 32'(seq_errs), 32'd0);
      clearMonitor();
      @(negedge cpu_clk);
      rst = 1'b0;

      // Full reload with random idle gaps
      sendHeader(8'h00, 1'b1);
      for (int i = 0; i < 16384; i++) applyStimulus(8'(i), 1'b1);
      checkOutput("full_done_before_chr", 32'(done), 32'd0);
      for (int i = 0; i < 8192; i++) applyStimulus(8'(i) ^ 8'hA5, 1'b1);
      checkOutput("full_done", 32'(done), 32'd1);
      checkOutput("full_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("full_err", 32'(err), 32'd0);
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 10; i++) applyStimulus(8'h77, 1'b0);
      #1;
      checkOutput("full_prg_strobes", 32'(prg_strobes), 32'd16384);
      checkOutput("full_chr_strobes", 32'(chr_strobes), 32'd8192);
      checkOutput("full_seq", 32'(seq_errs), 32'd0);
      checkOutput("full_both_we", 32'(both_we), 32'd0);
      checkOutput("full_final_done", 32'(final_ok), 32'd1);
      checkOutput("full_accepts", 32'(accepts), 32'd24592);
      checkOutput("full_done_sticky", 32'(done), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
